// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit.
//
// A Moore FSM sequences each instruction through fetch, decode and the
// execute/memory/writeback steps its opcode needs. Every datapath control is
// a decode of the current state. There are three exceptions that also look at
// inputs: ir_write and pc_en in FETCH follow mem_ready, and pc_en in BRANCH
// follows zero. An unsupported opcode parks the FSM in TRAP, where it stays
// until reset. A wrapping counter records how many instructions have retired.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   run          start fetching (sampled only in IDLE)
//   opcode       instr[31:26] from the instruction register
//   zero         ALU zero flag (branch condition)
//   mem_ready    memory completes the current access this cycle
//   mem_req      memory access request
//   mem_write    request is a write
//   iord         address select: 0 = PC, 1 = ALUOut
//   ir_write     instruction register enable
//   pc_en        PC enable
//   reg_write    register file write enable
//   reg_dst      write register select: 0 = rt, 1 = rd
//   mem_to_reg   write data select: 0 = ALUOut, 1 = MDR
//   alu_src_a    ALU A select: 0 = PC, 1 = A
//   alu_src_b    ALU B select: 00 = B, 01 = 4, 10 = sext, 11 = sext<<2
//   alu_op       ALU op class: 00 = add, 01 = sub, 10 = funct
//   pc_source    PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
//   state        current FSM state encoding
//   illegal      unsupported opcode trapped (sticky until reset)
//   instr_count  retired instruction count, wraps modulo 2^CNT_W

module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_en,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExecR  = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9,
        StJump   = 4'd10,
        StAddiEx = 4'd11,
        StAddiWb = 4'd12,
        StTrap   = 4'd15
    } state_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBSext  = 2'b10;
    localparam logic [1:0] SrcBSextS = 2'b11;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    state_e           state_q, state_d;
    logic             is_store_q, is_store_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;

    // State, load/store flavour and retire counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            count_q    <= count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        retire     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // Remember load vs store here so MEMADR does not depend on
                // the opcode input staying stable for another cycle.
                is_store_d = (opcode == OpSw);
                unique case (opcode)
                    OpRType:     state_d = StExecR;
                    OpLw, OpSw:  state_d = StMemAdr;
                    OpBeq:       state_d = StBranch;
                    OpJ:         state_d = StJump;
                    OpAddi:      state_d = StAddiEx;
                    default:     state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                state_d = is_store_q ? StMemWr : StMemRd;
            end
            StMemRd: begin
                if (mem_ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StMemWr: begin
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StExecR: begin
                state_d = StAluWb;
            end
            StAluWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StBranch: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StJump: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StAddiEx: begin
                state_d = StAddiWb;
            end
            StAddiWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                // Unused encodings recover to IDLE.
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (retire) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Control decode. Everything is 0 unless the state sets it.
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SrcBReg;
        alu_op     = AluAdd;
        pc_source  = PcAlu;
        illegal    = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                alu_src_b = SrcBFour;
                // IR and PC load only when the fetch actually completes.
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            StDecode: begin
                alu_src_b = SrcBSextS;
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBSext;
            end
            StMemRd: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            StExecR: begin
                alu_src_a = 1'b1;
                alu_op    = AluFunct;
            end
            StAluWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = AluSub;
                pc_source = PcAluOut;
                pc_en     = zero;
            end
            StJump: begin
                pc_source = PcJump;
                pc_en     = 1'b1;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBSext;
            end
            StAddiWb: begin
                reg_write = 1'b1;
            end
            StTrap: begin
                illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (built with a 4-bit counter so the
// wrap is reached quickly). Each instruction is expanded into its cycle-level
// path, and each state on that path is mapped to its control word. A single
// negedge process compares the DUT against that expectation.

module tb_multicycle_ctrl;

    localparam int unsigned CNT_W = 4;

    localparam int IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5,
                   MEMWR = 6, EXEC_R = 7, ALUWB = 8, BRANCH = 9, JUMP = 10,
                   ADDI_EX = 11, ADDI_WB = 12, TRAP = 15;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                           OP_BAD = 6'b111111;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_en;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    logic             clk;
    logic             reset;
    logic             run;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_en;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_write   (mem_write),
        .iord        (iord),
        .ir_write    (ir_write),
        .pc_en       (pc_en),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .pc_source   (pc_source),
        .state       (state),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    logic  check_en = 1'b0;
    int    exp_state = 0;
    ctrl_t exp_ctrl = '0;
    int    exp_count = 0;
    ctrl_t act_ctrl;

    assign act_ctrl = {mem_req, mem_write, iord, ir_write, pc_en, reg_write, reg_dst,
                       mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Control word each state must present.
    function automatic ctrl_t spec_ctrl(input int st, input logic mr, input logic z);
        ctrl_t c = '0;
        case (st)
            FETCH:   begin c.mem_req = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_en = mr; end
            DECODE:  c.alu_src_b = 2'b11;
            MEMADR:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            MEMRD:   begin c.mem_req = 1; c.iord = 1; end
            MEMWB:   begin c.reg_write = 1; c.mem_to_reg = 1; end
            MEMWR:   begin c.mem_req = 1; c.mem_write = 1; c.iord = 1; end
            EXEC_R:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            ALUWB:   begin c.reg_write = 1; c.reg_dst = 1; end
            BRANCH:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.pc_en = z; end
            JUMP:    begin c.pc_source = 2'b10; c.pc_en = 1; end
            ADDI_EX: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            ADDI_WB: c.reg_write = 1;
            TRAP:    c.illegal = 1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            check("state", 32'(state), 32'(exp_state));
            check("ctrl", 32'(act_ctrl), 32'(exp_ctrl));
            check("instr_count", 32'(instr_count), 32'(exp_count));
        end
    end

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs, publish expectation, advance to posedge+1.
    task automatic cyc(input int st, input logic mr, input logic z, inout int n);
        mem_ready = mr;
        zero      = z;
        exp_state = st;
        exp_ctrl  = spec_ctrl(st, mr, z);
        check_en  = 1'b1;
        n++;
        @(posedge clk);
        #1;
    endtask

    // Expand one instruction into its cycle path. fw/dw are wait cycles on the
    // fetch and data access. Returns the number of cycles it took.
    task automatic instr(input logic [5:0] op, input int fw, input int dw, input logic z,
                         output int n);
        n = 0;
        opcode = op;
        for (int i = 0; i < fw; i++) cyc(FETCH, 1'b0, rnd(), n);
        cyc(FETCH, 1'b1, rnd(), n);
        cyc(DECODE, rnd(), rnd(), n);
        case (op)
            OP_LW: begin
                cyc(MEMADR, rnd(), rnd(), n);
                for (int i = 0; i < dw; i++) cyc(MEMRD, 1'b0, rnd(), n);
                cyc(MEMRD, 1'b1, rnd(), n);
                cyc(MEMWB, rnd(), rnd(), n);
            end
            OP_SW: begin
                cyc(MEMADR, rnd(), rnd(), n);
                for (int i = 0; i < dw; i++) cyc(MEMWR, 1'b0, rnd(), n);
                cyc(MEMWR, 1'b1, rnd(), n);
            end
            OP_R: begin
                cyc(EXEC_R, rnd(), rnd(), n);
                cyc(ALUWB, rnd(), rnd(), n);
            end
            OP_ADDI: begin
                cyc(ADDI_EX, rnd(), rnd(), n);
                cyc(ADDI_WB, rnd(), rnd(), n);
            end
            OP_BEQ: cyc(BRANCH, rnd(), z, n);
            OP_J:   cyc(JUMP, rnd(), rnd(), n);
            default: begin
                for (int i = 0; i < 12; i++) cyc(TRAP, rnd(), rnd(), n);
                return;
            end
        endcase
        exp_count = (exp_count + 1) % (1 << CNT_W);
    endtask

    // One IDLE cycle with run high, then drop run for the rest of execution.
    task automatic start();
        int n;
        n = 0;
        run = 1'b1;
        cyc(IDLE, rnd(), rnd(), n);
        run = 1'b0;
    endtask

    task automatic do_reset_release();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        exp_count = 0;
    endtask

    initial begin
        int n;
        int dummy;
        logic [5:0] mix [5];
        mix[0] = OP_ADDI; mix[1] = OP_LW; mix[2] = OP_SW; mix[3] = OP_BEQ; mix[4] = OP_R;

        reset = 1'b0; run = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_ctrl", 32'(act_ctrl), 32'd0);
        check("reset_count", 32'(instr_count), 32'd0);
        @(posedge clk);
        do_reset_release();

        dummy = 0;
        cyc(IDLE, 1'b1, 1'b0, dummy);
        cyc(IDLE, 1'b0, 1'b1, dummy);
        start();

        instr(OP_R, 0, 0, 1'b0, n);
        check("lat_r", 32'(n), 32'd4);
        check("count_after_r", 32'(instr_count), 32'd1);
        instr(OP_LW, 0, 0, 1'b0, n);
        check("lat_lw", 32'(n), 32'd5);
        instr(OP_LW, 0, 3, 1'b0, n);
        check("lat_lw_wait3", 32'(n), 32'd8);
        instr(OP_SW, 0, 0, 1'b0, n);
        check("lat_sw", 32'(n), 32'd4);
        instr(OP_SW, 0, 2, 1'b0, n);
        instr(OP_ADDI, 0, 0, 1'b0, n);
        check("lat_addi", 32'(n), 32'd4);
        instr(OP_BEQ, 0, 0, 1'b1, n);
        check("lat_beq", 32'(n), 32'd3);
        instr(OP_BEQ, 0, 0, 1'b0, n);
        instr(OP_J, 0, 0, 1'b0, n);
        check("lat_j", 32'(n), 32'd3);
        instr(OP_R, 2, 0, 1'b0, n);
        for (int i = 0; i < 5; i++) instr(mix[i], i % 2, i % 3, logic'(i % 2), n);
        check("count_15", 32'(instr_count), 32'd15);
        instr(OP_J, 0, 0, 1'b0, n);
        check("count_wrap", 32'(instr_count), 32'd0);
        instr(OP_ADDI, 1, 0, 1'b0, n);

        // Unsupported opcode: sticky trap, count frozen.
        instr(OP_BAD, 0, 0, 1'b0, n);
        check("trap_illegal", 32'(illegal), 32'd1);
        check("trap_count", 32'(instr_count), 32'd1);

        check_en = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        check("trap_clr_illegal", 32'(illegal), 32'd0);
        check("trap_clr_state", 32'(state), 32'd0);
        check("trap_clr_count", 32'(instr_count), 32'd0);
        do_reset_release();

        // Reset in the middle of a store access.
        start();
        opcode = OP_SW;
        cyc(FETCH, 1'b1, 1'b0, dummy);
        cyc(DECODE, 1'b1, 1'b0, dummy);
        cyc(MEMADR, 1'b1, 1'b0, dummy);
        check_en  = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("memwr_req", 32'(mem_req), 32'd1);
        check("memwr_write", 32'(mem_write), 32'd1);
        reset = 1'b0;
        #1;
        check("async_req", 32'(mem_req), 32'd0);
        check("async_write", 32'(mem_write), 32'd0);
        check("async_state", 32'(state), 32'd0);
        run = 1'b0;
        do_reset_release();
        for (int i = 0; i < 4; i++) cyc(IDLE, rnd(), rnd(), dummy);
        check("idle_after_reset", 32'(state), 32'd0);
        check_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: CNT_W, default 32, width of the retired-instruction counter.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  reset, asynchronous, active-low.
REQ-004 Port: run  input  1  leave IDLE and start fetching.
REQ-005 Port: opcode  input  6  instr[31:26] from the instruction register.
REQ-006 Port: zero  input  1  ALU zero flag.
REQ-007 Port: mem_ready  input  1  memory completes the current access this cycle.
REQ-008 Port: mem_req  output  1  memory access request.
REQ-009 Port: mem_write  output  1  request is a write.
REQ-010 Port: iord  output  1  address select: 0 = PC, 1 = ALUOut.
REQ-011 Port: ir_write, pc_en, reg_write  output  1 each  register enables.
REQ-012 Port: reg_dst, mem_to_reg, alu_src_a  output  1 each  mux selects: rd/rt; MDR/ALUOut; A/PC.
REQ-013 Port: alu_src_b, alu_op, pc_source  output  2 each  mux selects: B/4/sext/sext<<2; add/sub/funct; ALU/ALUOut/jump.
REQ-014 Port: state  output  4  current FSM state.
REQ-015 Port: illegal  output  1  unsupported opcode trapped.
REQ-016 Port: instr_count  output  CNT_W  retired instructions.

Function
REQ-017 States and encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC_R=7, ALUWB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12, TRAP=15.
REQ-018 IDLE -> FETCH when run=1; otherwise hold IDLE; all outputs 0 in IDLE.
REQ-019 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; hold FETCH while mem_ready=0.
REQ-020 FETCH: ir_write and pc_en assert only in the cycle mem_ready=1; next state DECODE.
REQ-021 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; dispatch on opcode: 000000->EXEC_R, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDI_EX, any other -> TRAP.
REQ-022 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEMRD for lw, MEMWR for sw.
REQ-023 MEMRD: mem_req=1, iord=1; hold until mem_ready=1, then MEMWB.
REQ-024 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; next FETCH.
REQ-025 MEMWR: mem_req=1, mem_write=1, iord=1; hold until mem_ready=1, then FETCH.
REQ-026 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; next ALUWB. ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01; pc_en=zero; next FETCH.
REQ-028 JUMP: pc_source=10, pc_en=1; next FETCH.
REQ-029 ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00; next ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-030 TRAP: illegal=1, all other outputs 0; sticky until reset.
REQ-031 Controls are Moore decodes of state; only ir_write/pc_en in FETCH (mem_ready) and pc_en in BRANCH (zero) depend on inputs. Unlisted outputs are 0 in each state.
REQ-032 instr_count increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JUMP or ADDI_WB; wraps modulo 2^CNT_W; does not change on TRAP.
REQ-033 run is sampled only in IDLE; deasserting run mid-instruction has no effect.
REQ-034 Instruction latencies with mem_ready=1 immediately: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-035 reset=0 forces state=IDLE, instr_count=0, illegal=0 and all control outputs 0 immediately, without waiting for clk.
REQ-036 Reset asserted mid-access (mem_req=1) drops mem_req asynchronously; after release the FSM waits in IDLE for run.

Verification
REQ-037 Reset, run=1, opcode=000000, mem_ready=1 -> states 1,2,7,8,1; reg_write=1, reg_dst=1 in ALUWB; instr_count=1.
REQ-038 lw (100011) with mem_ready=0 for 3 cycles in MEMRD -> MEMRD held 4 cycles, mem_req=1/iord=1 throughout, then MEMWB with mem_to_reg=1.
REQ-039 beq (000100): zero=1 -> pc_en=1, pc_source=01 in BRANCH; zero=0 -> pc_en=0; both return to FETCH.
REQ-040 opcode=111111 in DECODE -> TRAP, illegal=1, held for 10+ cycles, instr_count unchanged; reset clears illegal.
REQ-041 Force instr_count to 2^CNT_W-1, complete j (000010) -> instr_count=0.
REQ-042 Assert reset in MEMWR with mem_write=1 -> mem_write, mem_req to 0 before next clk edge; state=0 after release with run=0.
